spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Two-requester round-robin front end for a single SPI master: grants one transfer at a time,
// supervises it with a timeout, and inserts a quiet gap before the next grant.
module spi_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [2:0]  wbytes0_i,
    input  logic [2:0]  wbytes1_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        spi_enable_o,
    output logic [31:0] spi_wdata_o,
    output logic [2:0]  spi_wbytes_o,
    input  logic [31:0] spi_rdata_i,
    input  logic [2:0]  spi_rbytes_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [7:0]  GAP_LAST    = 8'(GAP_CYCLES - 1);

    logic [1:0]  state_reg,  state_next;
    logic        ptr_reg,    ptr_next;
    logic        owner_reg,  owner_next;
    logic [1:0]  ack_reg,    ack_next;
    logic [1:0]  done_reg,   done_next;
    logic [31:0] rdata_reg,  rdata_next;
    logic        err_reg,    err_next;
    logic        busy_reg,   busy_next;
    logic        enable_reg, enable_next;
    logic [31:0] wdata_reg,  wdata_next;
    logic [2:0]  wbytes_reg, wbytes_next;
    logic [15:0] tcnt_reg,   tcnt_next;
    logic [7:0]  gcnt_reg,   gcnt_next;

    logic        grant_sel;
    logic [1:0]  grant_onehot;
    logic [1:0]  owner_onehot;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_wbytes;
    logic        sel_legal;
    logic        rbytes_match;
    logic        timeout_hit;

    // Priority goes to the pointer requester; fall back to the other one.
    assign grant_sel    = req_i[ptr_reg] ? ptr_reg : ~ptr_reg;
    assign sel_wdata    = grant_sel ? wdata1_i  : wdata0_i;
    assign sel_wbytes   = grant_sel ? wbytes1_i : wbytes0_i;
    assign sel_legal    = (sel_wbytes != 3'd0) && (sel_wbytes <= 3'd4);
    assign rbytes_match = (spi_rbytes_i == wbytes_reg);
    assign timeout_hit  = (tcnt_reg == TIMEOUT_LIM);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_onehot
            assign grant_onehot[gi] = (grant_sel == 1'(gi));
            assign owner_onehot[gi] = (owner_reg == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        ack_next    = 2'b00;
        done_next   = 2'b00;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        enable_next = enable_reg;
        wdata_next  = wdata_reg;
        wbytes_next = wbytes_reg;
        tcnt_next   = tcnt_reg;
        gcnt_next   = gcnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    ack_next    = grant_onehot;
                    wdata_next  = sel_wdata;
                    wbytes_next = sel_wbytes;
                    owner_next  = grant_sel;
                    ptr_next    = ~grant_sel;
                    if (sel_legal) begin
                        enable_next = 1'b1;
                        state_next  = ST_XFER;
                        tcnt_next   = 16'd0;
                    end else begin
                        // Unusable byte count: reject on the spot, never touch the bus.
                        done_next  = grant_onehot;
                        err_next   = 1'b1;
                        rdata_next = 32'd0;
                    end
                end
            end
            ST_XFER: begin
                // Completion is tested first so it wins over a coincident timeout.
                if (rbytes_match || timeout_hit) begin
                    done_next   = owner_onehot;
                    err_next    = ~rbytes_match;
                    rdata_next  = spi_rdata_i;
                    enable_next = 1'b0;
                    state_next  = ST_GAP;
                    gcnt_next   = 8'd0;
                end else begin
                    tcnt_next = tcnt_reg + 16'd1;
                end
            end
            ST_GAP: begin
                if (gcnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gcnt_next = gcnt_reg + 8'd1;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                enable_next = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= 1'b0;
            owner_reg  <= 1'b0;
            ack_reg    <= 2'b00;
            done_reg   <= 2'b00;
            rdata_reg  <= 32'd0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            enable_reg <= 1'b0;
            wdata_reg  <= 32'd0;
            wbytes_reg <= 3'd0;
            tcnt_reg   <= 16'd0;
            gcnt_reg   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            ack_reg    <= ack_next;
            done_reg   <= done_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
            busy_reg   <= busy_next;
            enable_reg <= enable_next;
            wdata_reg  <= wdata_next;
            wbytes_reg <= wbytes_next;
            tcnt_reg   <= tcnt_next;
            gcnt_reg   <= gcnt_next;
        end
    end

    assign ack_o        = ack_reg;
    assign done_o       = done_reg;
    assign rdata_o      = rdata_reg;
    assign err_o        = err_reg;
    assign busy_o       = busy_reg;
    assign spi_enable_o = enable_reg;
    assign spi_wdata_o  = wdata_reg;
    assign spi_wbytes_o = wbytes_reg;

endmodule
